// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - seven-segment constants and BCD segment lookup
package seven_seg_pkg;

   localparam int BCD_W = 4;
   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Active-low g..a patterns for BCD 0..9
   localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h18
   };

   function automatic logic [SEG_W-1:0] seg_lookup(input logic [BCD_W-1:0] code);
      logic [SEG_W-1:0] pat;
      pat = SEG_BLANK;
      for (int i = 0; i < 10; i++) begin
         if (code == BCD_W'(i)) pat = SEG_TABLE[i];
      end
      return pat;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - one digit: BCD code + dp + blank to active-low segment byte
module seg7_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] code,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg_n
);

   // The dp segment stays under dp control even when the digit is blanked
   assign seg_n = {~dp, blank ? SEG_BLANK : seg_lookup(code)};

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - double-buffered N-digit BCD scan display driver
module bcd_scan_display
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SCAN_DIV      = 50000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         upd_valid,
   output logic                         upd_ready,
   input  logic [BCD_W*NUM_DIGITS-1:0]  upd_digits,
   input  logic [NUM_DIGITS-1:0]        upd_dp,
   output logic [7:0]                   seg_n,
   output logic [NUM_DIGITS-1:0]        an_n,
   output logic [8*NUM_DIGITS-1:0]      disp_flat
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]              cnt;
   logic [IDX_W-1:0]              idx;
   logic                          tick;
   logic                          frame_end;
   logic                          pending;
   logic                          accept;
   logic [BCD_W*NUM_DIGITS-1:0]   shadow_digits;
   logic [NUM_DIGITS-1:0]         shadow_dp;
   logic [BCD_W*NUM_DIGITS-1:0]   active_digits;
   logic [NUM_DIGITS-1:0]         active_dp;
   logic [NUM_DIGITS-1:0]         blank;
   logic                          lead;
   logic [8*NUM_DIGITS-1:0]       dec_flat;
   logic [NUM_DIGITS-1:0]         an_next;

   assign tick      = (cnt == CNT_LAST);
   assign frame_end = tick && (idx == IDX_LAST);
   assign upd_ready = ~pending;
   assign accept    = upd_valid && !pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (tick) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow only moves to active on a frame boundary so a frame never mixes two values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_digits <= '0;
         shadow_dp     <= '0;
         active_digits <= '1;
         active_dp     <= '0;
         pending       <= 1'b0;
      end else if (frame_end && pending) begin
         active_digits <= shadow_digits;
         active_dp     <= shadow_dp;
         pending       <= 1'b0;
      end else if (accept) begin
         shadow_digits <= upd_digits;
         shadow_dp     <= upd_dp;
         pending       <= 1'b1;
      end
   end

   always_comb begin
      blank = '0;
      lead  = (BLANK_LEADING != 0);
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         blank[i] = lead && (active_digits[BCD_W*i +: BCD_W] == '0) && !active_dp[i];
         lead     = blank[i];
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg7_decode u_dec (
         .code  (active_digits[BCD_W*g +: BCD_W]),
         .dp    (active_dp[g]),
         .blank (blank[g]),
         .seg_n (dec_flat[8*g +: 8])
      );
   end

   always_comb begin
      an_next      = '1;
      an_next[idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_n     <= 8'hFF;
         an_n      <= '1;
         disp_flat <= '1;
      end else begin
         seg_n     <= dec_flat[{idx, 3'b000} +: 8];
         an_n      <= an_next;
         disp_flat <= dec_flat;
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - randomized model-checked bench for bcd_scan_display
module tb_bcd_scan_display;

   localparam int N  = 4;
   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        upd_valid;
   logic        upd_ready;
   logic [15:0] upd_digits;
   logic [3:0]  upd_dp;
   logic [7:0]  seg_n;
   logic [3:0]  an_n;
   logic [31:0] disp_flat;

   int errors = 0;
   int checks = 0;
   bit check_en = 0;

   bcd_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_LEADING(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_digits (upd_digits),
      .upd_dp     (upd_dp),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .disp_flat  (disp_flat)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

   // A digit is blank when it and every digit above it read as zero with no dp lit
   function automatic logic [7:0] model_digit(logic [15:0] act, logic [3:0] dp, int i);
      int  code;
      bit  blk;
      logic [6:0] s;
      code = int'((act >> (4*i)) & 16'hF);
      blk  = (i != 0) && ((act >> (4*i)) == 0) && ((dp >> i) == 0);
      s    = (blk || code > 9) ? 7'h7F : seg_ref[code];
      return {~dp[i], s};
   endfunction

   function automatic logic [31:0] model_flat(logic [15:0] act, logic [3:0] dp);
      logic [31:0] r;
      for (int i = 0; i < N; i++) r[8*i +: 8] = model_digit(act, dp, i);
      return r;
   endfunction

   int unsigned e;
   logic [15:0] m_active, m_shadow;
   logic [3:0]  m_dp, m_shadow_dp;
   logic        m_pending;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_an;
   logic [31:0] exp_flat;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e           <= 0;
         m_active    <= 16'hFFFF;
         m_dp        <= 4'h0;
         m_shadow    <= 16'h0;
         m_shadow_dp <= 4'h0;
         m_pending   <= 1'b0;
         exp_seg     <= 8'hFF;
         exp_an      <= 4'hF;
         exp_flat    <= 32'hFFFF_FFFF;
      end else begin
         exp_an   <= ~(4'b0001 << ((e / SD) % N));
         exp_seg  <= model_digit(m_active, m_dp, int'((e / SD) % N));
         exp_flat <= model_flat(m_active, m_dp);
         if (((e % (SD*N)) == SD*N - 1) && m_pending) begin
            m_active  <= m_shadow;
            m_dp      <= m_shadow_dp;
            m_pending <= 1'b0;
         end else if (upd_valid && !m_pending) begin
            m_shadow    <= upd_digits;
            m_shadow_dp <= upd_dp;
            m_pending   <= 1'b1;
         end
         e <= e + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("seg_n", {24'h0, seg_n}, {24'h0, exp_seg});
         check("an_n", {28'h0, an_n}, {28'h0, exp_an});
         check("disp_flat", disp_flat, exp_flat);
         check("upd_ready", {31'h0, upd_ready}, {31'h0, ~m_pending});
      end
   end

   task automatic send(input logic [15:0] d, input logic [3:0] dp);
      int tries = 0;
      @(negedge clk);
      upd_valid  = 1'b1;
      upd_digits = d;
      upd_dp     = dp;
      while (!upd_ready && tries < 200) begin
         @(negedge clk);
         tries++;
      end
      if (tries >= 200) check("send_timeout", 32'd1, 32'd0);
      @(negedge clk);
      upd_valid = 1'b0;
      check("busy_after_accept", {31'h0, upd_ready}, 32'd0);
   endtask

   task automatic wait_shown(input string name, input logic [31:0] exp);
      int tries = 0;
      while (!upd_ready && tries < 200) begin
         @(negedge clk);
         tries++;
      end
      if (tries >= 200) check("ready_timeout", 32'd1, 32'd0);
      @(negedge clk);
      check(name, disp_flat, exp);
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 1) == 0) r[4*i +: 4] = 4'd0;
         else if ($urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
         else r[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return r;
   endfunction

   function automatic logic [3:0] rand_dp();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 7) == 0);
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

   initial begin
      int acc;
      rst_n      = 1'b1;
      upd_valid  = 1'b0;
      upd_digits = '0;
      upd_dp     = '0;
      #1 rst_n = 1'b0;
      #2 check_en = 1;
      repeat (3) @(negedge clk);
      check("rst_seg", {24'h0, seg_n}, 32'hFF);
      check("rst_an", {28'h0, an_n}, 32'hF);
      check("rst_flat", disp_flat, 32'hFFFF_FFFF);
      check("rst_ready", {31'h0, upd_ready}, 32'd1);
      rst_n = 1'b1;

      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("an_scan", {28'h0, an_n}, {28'h0, an_seq[k]});
         repeat (4) @(negedge clk);
      end

      send(16'h1234, 4'b1000);
      wait_shown("show_1234", 32'h79A4_B099);
      send(16'h0007, 4'b0000);
      wait_shown("blank_0007", 32'hFFFF_FFF8);
      send(16'h0007, 4'b0100);
      wait_shown("blank_dp", 32'hFF40_C0F8);
      send(16'h00A5, 4'b0000);
      wait_shown("invalid_a5", 32'hFFFF_FF92);

      // Held valid with changing data: one accept per frame
      acc = 0;
      upd_valid = 1'b1;
      for (int j = 0; j < 46; j++) begin
         upd_digits = rand_digits();
         upd_dp     = rand_dp();
         if (upd_ready) acc++;
         @(negedge clk);
      end
      upd_valid = 1'b0;
      check("bp_accepts", acc, 32'd3);

      for (int j = 0; j < 600; j++) begin
         upd_valid  = ($urandom_range(0, 3) == 0);
         upd_digits = rand_digits();
         upd_dp     = rand_dp();
         @(negedge clk);
      end
      upd_valid = 1'b0;

      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'h9999, 4'b0000);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready", {31'h0, upd_ready}, 32'd1);
      check("midrst_flat", disp_flat, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("after_rst_flat", disp_flat, 32'hFFFF_FFFF);
      check("after_rst_ready", {31'h0, upd_ready}, 32'd1);

      check_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
